// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch stage with in-order response FIFO
//
// Purpose: owns the PC, issues word fetches over a req/gnt + in-order rvalid
// memory port, queues returned words with their PC and hands them to decode
// over valid/ready. Redirects from execute restart fetch and discard stale
// in-flight responses.
//
// Ports:
//   i_clk, i_rst_n                   clock, asynchronous active-low reset
//   o_imem_req/o_imem_addr           fetch request and word address
//   i_imem_gnt                       request accepted
//   i_imem_rvalid/i_imem_rdata       in-order response word
//   i_redirect/i_redirect_pc         taken branch/jump target
//   o_inst_valid/o_inst/o_inst_pc    head instruction toward decode
//   i_inst_ready                     decode consumes head
//
// Optional feature: FETCH_BYPASS_EN (zero-latency forward of a response into
// an empty FIFO).
module fetch_stage #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_inst_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_pc,
   input  logic        i_inst_ready
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int SW = CW + 2;
   localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);
   localparam logic [CW-1:0] ONE     = CW'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t        state, state_next;
   logic [31:0]   pc, resp_pc, redirect_target;
   logic [CW-1:0] live_cnt, kill_cnt, fifo_count;
   logic [CW-1:0] live_next, kill_next;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   mem_inst [FIFO_DEPTH];
   logic [31:0]   mem_pc   [FIFO_DEPTH];
   logic [SW-1:0] credit_used;
   logic          fire, rsp_drop, rsp_take, fifo_empty, bypass, push, pop;

   assign redirect_target = {i_redirect_pc[31:2], 2'b00};
   assign fifo_empty      = (fifo_count == '0);

   // Every outstanding request (live or doomed) and every buffered word holds
   // a FIFO slot, so a returning word always has room.
   assign credit_used = SW'(live_cnt) + SW'(kill_cnt) + SW'(fifo_count);
   assign o_imem_req  = (state != S_BOOT) && !i_redirect && (credit_used < DEPTH_S);
   assign o_imem_addr = pc;
   assign fire        = o_imem_req && i_imem_gnt;

   // Stale responses are always older than live ones, so they drain first.
   assign rsp_drop = i_imem_rvalid && (kill_cnt != '0);
   assign rsp_take = i_imem_rvalid && (kill_cnt == '0) && (live_cnt != '0);

`ifdef FETCH_BYPASS_EN
   assign bypass = fifo_empty && rsp_take && !i_redirect;
`else
   assign bypass = 1'b0;
`endif

   assign pop  = !fifo_empty && i_inst_ready;
   assign push = rsp_take && !i_redirect && !(bypass && i_inst_ready);

   always_comb begin
      o_inst_valid = 1'b0;
      o_inst       = '0;
      o_inst_pc    = '0;
      if (!fifo_empty) begin
         o_inst_valid = 1'b1;
         o_inst       = mem_inst[rd_ptr];
         o_inst_pc    = mem_pc[rd_ptr];
      end else if (bypass) begin
         o_inst_valid = 1'b1;
         o_inst       = i_imem_rdata;
         o_inst_pc    = resp_pc;
      end
   end

   // On redirect every live request becomes doomed; a response landing in the
   // same cycle retires one of them immediately.
   always_comb begin
      live_next = live_cnt;
      kill_next = kill_cnt;
      if (i_redirect) begin
         live_next = '0;
         kill_next = kill_cnt + live_cnt - ((rsp_drop || rsp_take) ? ONE : '0);
      end else begin
         live_next = live_cnt + (fire ? ONE : '0) - (rsp_take ? ONE : '0);
         kill_next = kill_cnt - (rsp_drop ? ONE : '0);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_BOOT:  state_next = S_RUN;
         S_RUN:   if (i_redirect && (kill_next != '0)) state_next = S_DRAIN;
         S_DRAIN: if (kill_next == '0) state_next = S_RUN;
         default: state_next = S_BOOT;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= S_BOOT;
         pc         <= RESET_ADDR;
         resp_pc    <= RESET_ADDR;
         live_cnt   <= '0;
         kill_cnt   <= '0;
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         state    <= state_next;
         live_cnt <= live_next;
         kill_cnt <= kill_next;
         if (i_redirect) begin
            pc         <= redirect_target;
            resp_pc    <= redirect_target;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
         end else begin
            if (fire)     pc      <= pc + 32'd4;
            if (rsp_take) resp_pc <= resp_pc + 32'd4;
            if (push)     wr_ptr  <= wr_ptr + PTR_ONE;
            if (pop)      rd_ptr  <= rd_ptr + PTR_ONE;
            fifo_count <= fifo_count + (push ? ONE : '0) - (pop ? ONE : '0);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_inst[wr_ptr] <= i_imem_rdata;
         mem_pc[wr_ptr]   <= resp_pc;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

   localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
   localparam int          FIFO_DEPTH = 2;
   localparam int          NVEC       = 19;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b0;

   fetch_stage #(.RESET_ADDR(RESET_ADDR), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .o_imem_req    (imem_req),
      .o_imem_addr   (imem_addr),
      .i_imem_gnt    (imem_gnt),
      .i_imem_rvalid (imem_rvalid),
      .i_imem_rdata  (imem_rdata),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_inst_valid  (inst_valid),
      .o_inst        (inst),
      .o_inst_pc     (inst_pc),
      .i_inst_ready  (inst_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] addr;
      int          cyc;
   } req_t;

   typedef struct {
      logic        gnt;
      logic        rv;
      logic [31:0] rsp_addr;
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
   } vec_t;

   vec_t        vt [NVEC];
   req_t        mem_q [$];
   logic [31:0] gnt_q [$];
   logic [31:0] dlv_q [$];
   logic [31:0] m_fetch_pc, m_exp_pc;
   int          cyc = 0;
   int          n_consumed = 0;
   int          p_gnt = 100, p_rv = 100, p_ready = 100, p_redir = 0;
   logic        force_redir = 1'b0;
   logic [31:0] force_pc = '0;
   logic        late_rv = 1'b0;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic setv(input int k, input logic gnt, input logic rv, input logic [31:0] rsp_addr,
                       input logic ready, input logic redir, input logic [31:0] rpc,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic e_valid, input logic [31:0] e_pc);
      vt[k] = '{gnt, rv, rsp_addr, ready, redir, rpc, e_req, e_addr, e_valid, e_pc};
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      redirect    = 1'b0;
      redirect_pc = '0;
      inst_ready  = 1'b0;
      mem_q.delete();
      gnt_q.delete();
      dlv_q.delete();
      m_fetch_pc = RESET_ADDR;
      m_exp_pc   = RESET_ADDR;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("boot_no_req", imem_req, 1'b0);
   endtask

   // One cycle of randomized memory/decode/execute behaviour plus the
   // stream-level reference model: fetch addresses and delivered PCs each
   // follow a simple +4 sequence restarted at every redirect target.
   task automatic step();
      logic  rv_real;
      req_t  r;
      @(posedge clk);
      #1;
      imem_gnt   = ($urandom_range(99) < p_gnt);
      inst_ready = ($urandom_range(99) < p_ready);
      rv_real    = 1'b0;
      if (mem_q.size() != 0 && mem_q[0].cyc < cyc && $urandom_range(99) < p_rv) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_f(mem_q[0].addr);
         rv_real     = 1'b1;
      end else if (late_rv) begin
         imem_rvalid = 1'b1;
         imem_rdata  = 32'hDEAD_BEEF;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      redirect    = force_redir || ($urandom_range(999) < p_redir);
      redirect_pc = force_redir ? force_pc : $urandom;
      @(negedge clk);
      if (redirect) check("req_during_redirect", imem_req, 1'b0);
      if (inst_valid && inst_ready) begin
         check("dlv_pc", inst_pc, m_exp_pc);
         check("dlv_inst", inst, mem_f(inst_pc));
         dlv_q.push_back(inst_pc);
         m_exp_pc = m_exp_pc + 32'd4;
         n_consumed++;
      end
      if (imem_req && imem_gnt) begin
         check("fetch_addr", imem_addr, m_fetch_pc);
         gnt_q.push_back(imem_addr);
         r.addr = imem_addr;
         r.cyc  = cyc;
         mem_q.push_back(r);
         m_fetch_pc = m_fetch_pc + 32'd4;
         check("inflight_bound", (mem_q.size() <= FIFO_DEPTH), 1'b1);
      end
      if (rv_real) void'(mem_q.pop_front());
      if (redirect) begin
         m_fetch_pc = {redirect_pc[31:2], 2'b00};
         m_exp_pc   = {redirect_pc[31:2], 2'b00};
      end
      cyc++;
   endtask

   initial begin
      // gnt rv rsp   rdy rdr rpc     | req addr   valid pc
      setv( 0, 1, 0, 32'h0,   1, 0, 32'h0,   0, 32'h0,   0, 32'h0);
      setv( 1, 1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h0,   0, 32'h0);
      setv( 2, 1, 1, 32'h0,   1, 0, 32'h0,   1, 32'h4,   0, 32'h0);
      setv( 3, 1, 1, 32'h4,   1, 0, 32'h0,   0, 32'h8,   1, 32'h0);
      setv( 4, 1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h8,   1, 32'h4);
      setv( 5, 1, 1, 32'h8,   1, 0, 32'h0,   1, 32'hC,   0, 32'h0);
      setv( 6, 1, 1, 32'hC,   0, 0, 32'h0,   0, 32'h10,  1, 32'h8);
      setv( 7, 1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h10,  1, 32'h8);
      setv( 8, 1, 0, 32'h0,   1, 0, 32'h0,   0, 32'h10,  1, 32'h8);
      setv( 9, 0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h10,  1, 32'hC);
      setv(10, 1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h10,  0, 32'h0);
      setv(11, 1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h14,  0, 32'h0);
      setv(12, 0, 0, 32'h0,   1, 1, 32'h103, 0, 32'h18,  0, 32'h0);
      setv(13, 0, 1, 32'h10,  1, 0, 32'h0,   0, 32'h100, 0, 32'h0);
      setv(14, 1, 1, 32'h14,  1, 0, 32'h0,   1, 32'h100, 0, 32'h0);
      setv(15, 0, 1, 32'h100, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0);
      setv(16, 0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h104, 1, 32'h100);
      setv(17, 0, 0, 32'h0,   1, 1, 32'h200, 0, 32'h104, 1, 32'h100);
      setv(18, 0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h200, 0, 32'h0);

      @(negedge clk);
      check("rst_req", imem_req, 1'b0);
      check("rst_addr", imem_addr, RESET_ADDR);
      check("rst_valid", inst_valid, 1'b0);
      check("rst_inst", inst, 32'h0);
      check("rst_inst_pc", inst_pc, 32'h0);

`ifndef FETCH_BYPASS_EN
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < NVEC; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         imem_gnt    = vt[k].gnt;
         imem_rvalid = vt[k].rv;
         imem_rdata  = mem_f(vt[k].rsp_addr);
         inst_ready  = vt[k].ready;
         redirect    = vt[k].redir;
         redirect_pc = vt[k].rpc;
         @(negedge clk);
         check($sformatf("tbl%0d_req", k), imem_req, vt[k].e_req);
         check($sformatf("tbl%0d_addr", k), imem_addr, vt[k].e_addr);
         check($sformatf("tbl%0d_valid", k), inst_valid, vt[k].e_valid);
         if (vt[k].e_valid) begin
            check($sformatf("tbl%0d_pc", k), inst_pc, vt[k].e_pc);
            check($sformatf("tbl%0d_inst", k), inst, mem_f(vt[k].e_pc));
         end
      end
`endif

      // PC wrap at the top of the address space.
      do_reset();
      p_gnt = 100; p_rv = 100; p_ready = 100; p_redir = 0;
      force_redir = 1'b1;
      force_pc    = 32'hFFFF_FFFC;
      step();
      force_redir = 1'b0;
      repeat (10) step();
      check("wrap_gnt_cnt", (gnt_q.size() >= 2), 1'b1);
      check("wrap_dlv_cnt", (dlv_q.size() >= 2), 1'b1);
      if (gnt_q.size() >= 2) begin
         check("wrap_gnt0", gnt_q[0], 32'hFFFF_FFFC);
         check("wrap_gnt1", gnt_q[1], 32'h0000_0000);
      end
      if (dlv_q.size() >= 2) begin
         check("wrap_dlv0", dlv_q[0], 32'hFFFF_FFFC);
         check("wrap_dlv1", dlv_q[1], 32'h0000_0000);
      end

      // Reset in the middle of a stream with a request still outstanding.
      p_rv = 0;
      repeat (3) step();
      check("pre_rst_inflight", (mem_q.size() >= 1), 1'b1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_req", imem_req, 1'b0);
      check("midrst_valid", inst_valid, 1'b0);
      check("midrst_inst", inst, 32'h0);
      check("midrst_inst_pc", inst_pc, 32'h0);
      imem_gnt = 1'b0;
      redirect = 1'b0;
      mem_q.delete();
      gnt_q.delete();
      dlv_q.delete();
      m_fetch_pc = RESET_ADDR;
      m_exp_pc   = RESET_ADDR;
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      check("midrst_boot_req", imem_req, 1'b0);
      p_rv    = 100;
      late_rv = 1'b1;
      step();
      late_rv = 1'b0;
      repeat (10) step();
      check("midrst_gnt_cnt", (gnt_q.size() >= 1), 1'b1);
      check("midrst_dlv_cnt", (dlv_q.size() >= 1), 1'b1);
      if (gnt_q.size() >= 1) check("midrst_first_fetch", gnt_q[0], RESET_ADDR);
      if (dlv_q.size() >= 1) check("midrst_first_dlv", dlv_q[0], RESET_ADDR);

      // Randomized traffic with redirects.
      do_reset();
      p_gnt = 70; p_rv = 60; p_ready = 70; p_redir = 40;
      n_consumed = 0;
      repeat (3000) step();
      check("random_progress", (n_consumed > 200), 1'b1);

`ifdef FETCH_BYPASS_EN
      do_reset();
      @(posedge clk);
      #1;
      imem_gnt   = 1'b1;
      inst_ready = 1'b1;
      @(negedge clk);
      check("byp_req", imem_req, 1'b1);
      @(posedge clk);
      #1;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = mem_f(RESET_ADDR);
      @(negedge clk);
      check("byp_valid", inst_valid, 1'b1);
      check("byp_pc", inst_pc, RESET_ADDR);
      check("byp_inst", inst, mem_f(RESET_ADDR));
      @(posedge clk);
      #1 imem_rvalid = 1'b0;
      @(negedge clk);
      check("byp_nopush", inst_valid, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
